// File: rtl/systolic_tile_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : systolic_tile_scheduler_if                                      |
// | Purpose  : Control bus between the tile scheduler and the FIFO-fed         |
// |            systolic datapath.                                              |
// | Signals  : dp_enb        scheduler -> datapath  run enable                 |
// |            dp_clear      scheduler -> datapath  one-cycle restart          |
// |            dp_base_addr  scheduler -> datapath  current tile base address  |
// |            dp_K          scheduler -> datapath  reduction length           |
// |            dp_stall      datapath -> scheduler  FIFO-empty stall           |
// |            dp_done       datapath -> scheduler  all producers finished     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface systolic_tile_scheduler_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  dp_enb;
  logic                  dp_clear;
  logic [ADDR_WIDTH-1:0] dp_base_addr;
  logic [31:0]           dp_K;
  logic                  dp_stall;
  logic                  dp_done;

  // Scheduler side
  modport master (
    output dp_enb, dp_clear, dp_base_addr, dp_K,
    input  dp_stall, dp_done
  );

  // Datapath side
  modport slave (
    input  dp_enb, dp_clear, dp_base_addr, dp_K,
    output dp_stall, dp_done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : systolic_tile_scheduler                                         |
// | Purpose  : Sequences one job of N tiles through the systolic datapath:     |
// |            program base address, clear, run until dp_done, then wait out   |
// |            the array skew before the next tile.                            |
// | Ports    : clk, rstn (async active-low)                                    |
// |            start, abort                  job control                       |
// |            cfg_base_addr/K/tile_stride/num_tiles  job configuration        |
// |            dp (master modport)           datapath control bus              |
// |            busy, done, aborted, cfg_err  job status                        |
// |            tile_idx, stall_cycles        progress and stall statistics     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module systolic_tile_scheduler #(
  parameter int TILE_DIM     = 64,
  parameter int ADDR_WIDTH   = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 2*TILE_DIM-1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [31:0]           cfg_K,
  input  logic [ADDR_WIDTH-1:0] cfg_tile_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_num_tiles,
  systolic_tile_scheduler_if.master dp,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  cfg_err,
  output logic [CNT_WIDTH-1:0]  tile_idx,
  output logic [31:0]           stall_cycles
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] stride;
  logic [CNT_WIDTH-1:0]  last_idx;   // num_tiles-1, so the last-tile test is a plain compare
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  first_run;  // set for the first RUN cycle of each tile
  logic                  start_ok;

  assign start_ok = (cfg_num_tiles != '0) && (cfg_K != 32'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      stride          <= '0;
      last_idx        <= '0;
      drain_cnt       <= '0;
      first_run       <= 1'b0;
      dp.dp_enb       <= 1'b0;
      dp.dp_clear     <= 1'b0;
      dp.dp_base_addr <= '0;
      dp.dp_K         <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      cfg_err         <= 1'b0;
      tile_idx        <= '0;
      stall_cycles    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              dp.dp_K         <= cfg_K;
              stride          <= cfg_tile_stride;
              last_idx        <= cfg_num_tiles - CNT_WIDTH'(1);
              dp.dp_base_addr <= cfg_base_addr;
              tile_idx        <= '0;
              stall_cycles    <= 32'd0;
              aborted         <= 1'b0;
              cfg_err         <= 1'b0;
              busy            <= 1'b1;
              // dp_clear is registered, so raise it on entry to LAUNCH
              dp.dp_clear     <= 1'b1;
              state           <= ST_LAUNCH;
            end else begin
              cfg_err <= 1'b1;
              done    <= 1'b1;
              state   <= ST_FINISH;
            end
          end
        end

        ST_LAUNCH: begin
          dp.dp_clear <= 1'b0;
          if (abort) begin
            dp.dp_enb <= 1'b0;
            aborted   <= 1'b1;
            done      <= 1'b1;
            state     <= ST_FINISH;
          end else begin
            dp.dp_enb <= 1'b1;
            first_run <= 1'b1;
            state     <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (dp.dp_stall && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
          first_run <= 1'b0;
          if (abort) begin
            dp.dp_enb <= 1'b0;
            aborted   <= 1'b1;
            done      <= 1'b1;
            state     <= ST_FINISH;
          end else if (dp.dp_done && !first_run) begin
            // dp_done in the first RUN cycle may be left over from the previous tile
            dp.dp_enb <= 1'b0;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            state     <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= ST_FINISH;
          end else if (drain_cnt == DRAIN_W'(1)) begin
            if (tile_idx == last_idx) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              tile_idx        <= tile_idx + CNT_WIDTH'(1);
              dp.dp_base_addr <= dp.dp_base_addr + stride;
              dp.dp_clear     <= 1'b1;
              state           <= ST_LAUNCH;
            end
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end

        ST_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_systolic_tile_scheduler                                      |
// | Purpose  : Self-checking bench for systolic_tile_scheduler. Each job is    |
// |            described by tile run lengths; a timeline model derives the     |
// |            expected outputs for every cycle, plus literal spot checks.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_systolic_tile_scheduler;

  localparam int TILE_DIM = 4;
  localparam int DRAIN    = 2*TILE_DIM-1;
  localparam int AW       = 16;
  localparam int CW       = 16;
  localparam int MAXC     = 200;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [31:0]   cfg_K = '0;
  logic [AW-1:0] cfg_tile_stride = '0;
  logic [CW-1:0] cfg_num_tiles = '0;
  logic          busy, done, aborted, cfg_err;
  logic [CW-1:0] tile_idx;
  logic [31:0]   stall_cycles;

  systolic_tile_scheduler_if #(.ADDR_WIDTH(AW)) dpif();

  systolic_tile_scheduler #(
    .TILE_DIM(TILE_DIM), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_K(cfg_K),
    .cfg_tile_stride(cfg_tile_stride), .cfg_num_tiles(cfg_num_tiles),
    .dp(dpif),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .tile_idx(tile_idx), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  bit mon_on = 1'b0;

  // job description
  logic [AW-1:0] j_base, j_stride;
  logic [31:0]   j_K;
  int            j_tiles, j_abort_at, j_mid, j_stall_mode, job_len;
  int            j_n[8];
  bit            j_stale, j_abort_idle;

  // stimulus and expected timeline, indexed by cycle within the job
  bit          st_start[MAXC], st_abort[MAXC], st_done[MAXC], st_stall[MAXC];
  logic [31:0] e_enb[MAXC], e_clr[MAXC], e_base[MAXC], e_idx[MAXC], e_K[MAXC];
  logic [31:0] e_busy[MAXC], e_done[MAXC], e_ab[MAXC], e_err[MAXC], e_stall[MAXC];

  // values the outputs hold between jobs
  logic [31:0] prev_base = 0, prev_idx = 0, prev_K = 0, prev_ab = 0, prev_err = 0, prev_stall = 0;

  // monitor records
  int          nclr, nenb, ndone, nbusy, first_clr, enb_first, enb_last, done_cyc;
  logic [31:0] clr_base[8];

  function automatic logic [31:0] b2w(input bit x);
    return x ? 32'd1 : 32'd0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [31:0] k, input int tiles,
                         input int n0, input int n1, input int n2, input int n3);
    j_base = base; j_stride = stride; j_K = k; j_tiles = tiles;
    j_n[0] = n0; j_n[1] = n1; j_n[2] = n2; j_n[3] = n3;
    for (int i = 4; i < 8; i++) j_n[i] = 2;
    j_abort_at = -1; j_mid = -1; j_stall_mode = 0; j_stale = 0; j_abort_idle = 0;
  endtask

  // Timeline model: tile t launches at L[t]; it runs n[t] cycles (dp_done in
  // the n-th), drains DRAIN cycles, and the next launch follows immediately.
  task automatic build();
    int L[8];
    int F, t, cnt;
    logic [31:0] b;
    for (int c = 0; c < MAXC; c++) begin
      st_start[c] = 0; st_abort[c] = 0; st_done[c] = 0;
      st_stall[c] = (j_stall_mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
      e_enb[c] = 0; e_clr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_base[c] = prev_base; e_idx[c] = prev_idx; e_K[c] = prev_K;
      e_ab[c] = prev_ab; e_err[c] = prev_err; e_stall[c] = prev_stall;
    end
    st_start[0] = 1;
    st_abort[0] = j_abort_idle;
    if (j_tiles == 0 || j_K == 0) begin
      job_len = 4;
      st_abort[1] = 1;
      e_done[1] = 1;
      for (int c = 1; c < MAXC; c++) e_err[c] = 1;
    end else begin
      L[0] = 1;
      for (int i = 1; i < 8; i++) L[i] = (i < j_tiles) ? L[i-1] + j_n[i-1] + DRAIN + 1 : 1000000;
      F = L[j_tiles-1] + j_n[j_tiles-1] + DRAIN + 1;
      if (j_abort_at >= 0) F = j_abort_at + 1;
      job_len = F + 3;
      for (int i = 0; i < j_tiles; i++)
        if (L[i] + j_n[i] < MAXC) st_done[L[i] + j_n[i]] = 1;
      if (j_stale)
        for (int c = L[0] + j_n[0]; c <= L[1] + 1; c++) st_done[c] = 1;
      if (j_stall_mode == 1) begin
        for (int c = L[0] + 1; c <= L[0] + 5; c++) st_stall[c] = 1;
        for (int c = L[1] + 2; c <= L[1] + 4; c++) st_stall[c] = 1;
        for (int i = 0; i < j_tiles; i++)
          for (int c = L[i] + j_n[i] + 1; c <= L[i] + j_n[i] + DRAIN; c++) st_stall[c] = 1;
      end
      if (j_mid >= 0) st_start[j_mid] = 1;
      if (j_abort_at >= 0) st_abort[j_abort_at] = 1;
      else begin st_abort[F] = 1; st_abort[F+2] = 1; end
      cnt = 0;
      for (int c = 1; c < MAXC; c++) begin
        t = 0;
        for (int i = 1; i < 8; i++) if (L[i] <= c && L[i] < F) t = i;
        b = 32'(j_base) + 32'(t) * 32'(j_stride);
        e_base[c] = {16'd0, b[15:0]};
        e_idx[c]  = 32'(t);
        e_K[c]    = j_K;
        e_err[c]  = 0;
        e_ab[c]   = b2w(j_abort_at >= 0 && c >= F);
        e_busy[c] = b2w(c <= F);
        e_done[c] = b2w(c == F);
        e_clr[c]  = b2w(c < F && c == L[t]);
        e_enb[c]  = b2w(c < F && c > L[t] && c <= L[t] + j_n[t]);
        e_stall[c] = 32'(cnt);
        if (e_enb[c] != 0 && st_stall[c]) cnt++;
      end
    end
    prev_base = e_base[job_len-1]; prev_idx = e_idx[job_len-1]; prev_K = e_K[job_len-1];
    prev_ab = e_ab[job_len-1]; prev_err = e_err[job_len-1]; prev_stall = e_stall[job_len-1];
  endtask

  task automatic clr_mon();
    nclr = 0; nenb = 0; ndone = 0; nbusy = 0;
    first_clr = -1; enb_first = -1; enb_last = -1; done_cyc = -1;
  endtask

  task automatic run_job(input int stop);
    for (int c = 0; c < stop; c++) begin
      @(posedge clk); #1;
      cyc = c; chk_on = 1; mon_on = 1;
      start = st_start[c]; abort = st_abort[c];
      dpif.dp_done = st_done[c]; dpif.dp_stall = st_stall[c];
      if (c == 0) begin
        cfg_base_addr = j_base; cfg_K = j_K; cfg_tile_stride = j_stride; cfg_num_tiles = CW'(j_tiles);
      end else begin
        cfg_base_addr = AW'($urandom); cfg_K = $urandom; cfg_tile_stride = AW'($urandom);
        cfg_num_tiles = CW'($urandom);
      end
    end
    @(posedge clk); #1;
    chk_on = 0; mon_on = 0;
    start = 0; abort = 0; dpif.dp_done = 0; dpif.dp_stall = 0;
  endtask

  // single compare process against the model timeline
  always @(negedge clk) begin
    if (chk_on) begin
      chk("dp_enb",       64'(dpif.dp_enb),       64'(e_enb[cyc]));
      chk("dp_clear",     64'(dpif.dp_clear),     64'(e_clr[cyc]));
      chk("dp_base_addr", 64'(dpif.dp_base_addr), 64'(e_base[cyc]));
      chk("dp_K",         64'(dpif.dp_K),         64'(e_K[cyc]));
      chk("busy",         64'(busy),              64'(e_busy[cyc]));
      chk("done",         64'(done),              64'(e_done[cyc]));
      chk("aborted",      64'(aborted),           64'(e_ab[cyc]));
      chk("cfg_err",      64'(cfg_err),           64'(e_err[cyc]));
      chk("tile_idx",     64'(tile_idx),          64'(e_idx[cyc]));
      chk("stall_cycles", 64'(stall_cycles),      64'(e_stall[cyc]));
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (dpif.dp_clear) begin
        if (nclr < 8) clr_base[nclr] = 32'(dpif.dp_base_addr);
        if (nclr == 0) first_clr = cyc;
        nclr++;
      end
      if (dpif.dp_enb) begin
        if (nenb == 0) enb_first = cyc;
        enb_last = cyc;
        nenb++;
      end
      if (done) begin ndone++; done_cyc = cyc; end
      if (busy) nbusy++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    dpif.dp_done = 0; dpif.dp_stall = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset dp_enb", 64'(dpif.dp_enb), 64'd0);
    rstn = 1;

    // single tile, abort together with start in IDLE
    set_job(16'h0100, 16'h0000, 32'd8, 1, 5, 0, 0, 0);
    j_abort_idle = 1;
    build(); clr_mon(); run_job(job_len);
    chk("t1 first clear cycle", 64'(first_clr), 64'd1);
    chk("t1 first enb cycle", 64'(enb_first), 64'd2);
    chk("t1 last enb cycle", 64'(enb_last), 64'd6);
    chk("t1 done cycle", 64'(done_cyc), 64'd14);
    chk("t1 done pulses", 64'(ndone), 64'd1);
    chk("t1 base", 64'(clr_base[0]), 64'h100);

    // three tiles with address wrap, start ignored mid-job
    set_job(16'hFFC0, 16'h0040, 32'd100, 3, 3, 4, 2, 0);
    j_mid = 5; j_stall_mode = 2;
    build(); clr_mon(); run_job(job_len);
    chk("t2 clear pulses", 64'(nclr), 64'd3);
    chk("t2 base0", 64'(clr_base[0]), 64'hFFC0);
    chk("t2 base1", 64'(clr_base[1]), 64'h0000);
    chk("t2 base2", 64'(clr_base[2]), 64'h0040);
    chk("t2 done pulses", 64'(ndone), 64'd1);

    // stale dp_done held across LAUNCH
    set_job(16'h0010, 16'h0010, 32'd3, 2, 3, 2, 0, 0);
    j_stale = 1;
    build(); clr_mon(); run_job(job_len);
    chk("t3 enb cycles", 64'(nenb), 64'd5);

    // stall statistics
    set_job(16'h0200, 16'h0020, 32'd7, 2, 6, 4, 0, 0);
    j_stall_mode = 1;
    build(); clr_mon(); run_job(job_len);
    chk("t4 stall_cycles", 64'(stall_cycles), 64'd8);

    // abort in RUN of tile 1 of 4 (tile 1 launches at 13)
    set_job(16'h0400, 16'h0100, 32'd9, 4, 4, 4, 4, 4);
    j_abort_at = 15;
    build(); clr_mon(); run_job(job_len);
    chk("t5 clear pulses", 64'(nclr), 64'd2);
    chk("t5 done pulses", 64'(ndone), 64'd1);
    chk("t5 aborted", 64'(aborted), 64'd1);

    // a following valid job clears aborted
    set_job(16'h0800, 16'h0000, 32'd1, 1, 3, 0, 0, 0);
    build(); clr_mon(); run_job(job_len);
    chk("t6 aborted", 64'(aborted), 64'd0);
    chk("t6 done pulses", 64'(ndone), 64'd1);

    // illegal configurations
    set_job(16'h1234, 16'h0010, 32'd5, 0, 2, 0, 0, 0);
    build(); clr_mon(); run_job(job_len);
    chk("t7 cfg_err", 64'(cfg_err), 64'd1);
    chk("t7 clear pulses", 64'(nclr), 64'd0);
    chk("t7 busy cycles", 64'(nbusy), 64'd0);
    chk("t7 done pulses", 64'(ndone), 64'd1);
    set_job(16'h1234, 16'h0010, 32'd0, 3, 2, 2, 2, 0);
    build(); clr_mon(); run_job(job_len);
    chk("t8 cfg_err", 64'(cfg_err), 64'd1);
    chk("t8 clear pulses", 64'(nclr), 64'd0);

    // asynchronous reset during DRAIN of tile 1 (drain spans cycles 16..22)
    set_job(16'h0300, 16'h0030, 32'd11, 2, 3, 3, 0, 0);
    j_stall_mode = 2;
    build(); clr_mon(); run_job(18);
    #2 rstn = 0;
    #1;
    chk("rst dp_enb", 64'(dpif.dp_enb), 64'd0);
    chk("rst dp_clear", 64'(dpif.dp_clear), 64'd0);
    chk("rst dp_base_addr", 64'(dpif.dp_base_addr), 64'd0);
    chk("rst dp_K", 64'(dpif.dp_K), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst tile_idx", 64'(tile_idx), 64'd0);
    chk("rst stall_cycles", 64'(stall_cycles), 64'd0);
    clr_mon(); mon_on = 1;
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (6) @(negedge clk);
    mon_on = 0;
    chk("rst done pulses", 64'(ndone), 64'd0);
    chk("rst busy cycles", 64'(nbusy), 64'd0);
    prev_base = 0; prev_idx = 0; prev_K = 0; prev_ab = 0; prev_err = 0; prev_stall = 0;

    // recovery after reset, minimum run length
    set_job(16'h0050, 16'h0000, 32'd2, 1, 2, 0, 0, 0);
    build(); clr_mon(); run_job(job_len);
    chk("t10 done pulses", 64'(ndone), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
